// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl
// MEM-stage data-memory sequencer. Turns the EX/MEM MemRead/MemWrite strobes
// into a req/ack transaction with a multi-cycle data memory. While the
// transaction is in flight, pipe_stall freezes the upstream pipeline registers.
// When the access finishes, a single load_valid pulse lets the pipeline advance.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no access outstanding; a MemRead/MemWrite launches one
// BUSY  | dmem_req asserted, waiting for dmem_ack or for the timeout
// DONE  | access finished; one-cycle release of the pipeline
module dmem_access_ctrl #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              pipe_stall,
    output logic [DATA_W-1:0] load_data,
    output logic              load_valid,
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    // The access is abandoned on the last of TIMEOUT BUSY cycles without ack.
    localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);

    state_t              state_q;
    logic [TO_W-1:0]     cnt_q;
    logic                req_q;
    logic                we_q;
    logic [DATA_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   load_data_q;
    logic                load_valid_q;
    logic                timeout_q;
    logic                access_req;

    assign access_req = mem_read | mem_write;

    // Sequencer state, BUSY-cycle counter and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            load_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (access_req) begin
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        // A write wins when both strobes are high.
                        we_q    <= mem_write;
                        req_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    // An ack that arrives on the final cycle still completes normally.
                    if (dmem_ack) begin
                        req_q        <= 1'b0;
                        load_valid_q <= 1'b1;
                        if (!we_q) begin
                            load_data_q <= dmem_rdata;
                        end
                        state_q <= DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        req_q        <= 1'b0;
                        timeout_q    <= 1'b1;
                        load_data_q  <= '0;
                        load_valid_q <= 1'b1;
                        state_q      <= DONE;
                    end else begin
                        cnt_q <= cnt_q + TO_W'(1);
                    end
                end
                DONE: begin
                    // EX/MEM still holds the finished instruction, so its strobes are ignored here.
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
                default: begin
                    req_q   <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // The stall is raised in the same cycle as the strobe so EX/MEM cannot advance past the access.
    always_comb begin
        pipe_stall = 1'b0;
        case (state_q)
            IDLE:    pipe_stall = access_req;
            BUSY:    pipe_stall = 1'b1;
            default: pipe_stall = 1'b0;
        endcase
    end

    assign dmem_req    = req_q;
    assign dmem_we     = we_q;
    assign dmem_addr   = addr_q;
    assign dmem_wdata  = wdata_q;
    assign load_data   = load_data_q;
    assign load_valid  = load_valid_q;
    assign timeout_err = timeout_q;

endmodule
